// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory sequencer for the simpleCPU datapath.
// Optional retired-instruction counter: define CPU_SEQ_INSTR_COUNT_EN.
module cpu_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int OPW         = 4
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Run,
  input  logic [OPW-1:0] Opcode,
  input  logic           Zero,
  input  logic           MemReady,
  output logic           MemRd,
  output logic           MemWr,
  output logic           IrLoad,
  output logic           PcInc,
  output logic           PcLoad,
  output logic           RegWe,
  output logic [2:0]     AluOp,
  output logic [2:0]     State,
  output logic           Halted,
  output logic           Fault,
  output logic [15:0]    InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4);
  localparam logic [OPW-1:0] OP_LD  = OPW'(5);
  localparam logic [OPW-1:0] OP_ST  = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  state_t         state;
  logic [OPW-1:0] op_q;
  logic [7:0]     tmo_cnt;
  logic           fault_q;
  logic           is_mem_op;
  logic           timeout;

  assign is_mem_op = (op_q == OP_LD) || (op_q == OP_ST);
  assign timeout   = (tmo_cnt == 8'(MEM_TIMEOUT));

  // Memory handshake: a request is held until MemReady completes it, or the
  // wait counter reaches MEM_TIMEOUT, in which case the sequencer faults.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      tmo_cnt <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Run) begin
            state   <= S_FETCH;
            tmo_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (MemReady) begin
            state <= S_DECODE;
          end else if (timeout) begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          op_q  <= Opcode;
          state <= (Opcode == OP_HLT) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          tmo_cnt <= '0;
          if (is_mem_op) begin
            state <= S_MEM;
          end else begin
            state <= Run ? S_FETCH : S_IDLE;
          end
        end
        S_MEM: begin
          if (MemReady) begin
            state   <= Run ? S_FETCH : S_IDLE;
            tmo_cnt <= '0;
          end else if (timeout) begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    MemRd  = 1'b0;
    MemWr  = 1'b0;
    IrLoad = 1'b0;
    PcInc  = 1'b0;
    PcLoad = 1'b0;
    RegWe  = 1'b0;
    AluOp  = 3'd0;
    case (state)
      S_FETCH: begin
        MemRd  = 1'b1;
        IrLoad = MemReady;
        PcInc  = MemReady;
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD:  begin AluOp = 3'd1; RegWe = 1'b1; end
          OP_SUB:  begin AluOp = 3'd2; RegWe = 1'b1; end
          OP_AND:  begin AluOp = 3'd3; RegWe = 1'b1; end
          OP_OR:   begin AluOp = 3'd4; RegWe = 1'b1; end
          OP_JMP:  PcLoad = 1'b1;
          OP_JZ:   PcLoad = Zero;
          default: ;
        endcase
      end
      S_MEM: begin
        if (op_q == OP_LD) begin
          MemRd = 1'b1;
          RegWe = MemReady;
        end else begin
          MemWr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign State  = state;
  assign Halted = (state == S_HALT);
  assign Fault  = fault_q;

`ifdef CPU_SEQ_INSTR_COUNT_EN
  logic        retire;
  logic [15:0] instr_cnt;

  // An instruction retires when EXEC leaves for anywhere but MEM, or MEM completes.
  assign retire = ((state == S_EXEC) && !is_mem_op) || ((state == S_MEM) && MemReady);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      instr_cnt <= '0;
    end else if (retire) begin
      instr_cnt <= instr_cnt + 16'd1;
    end
  end

  assign InstrCount = instr_cnt;
`else
  assign InstrCount = 16'h0000;
`endif

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the simpleCPU datapath.
- Drives the load and enable strobes of the PC, instruction register, register file and memory port. These registers are built from the team's edge-triggered flip-flop cells.
- Steps each instruction through fetch/decode/execute/memory, waits on a memory ready handshake, and aborts on a memory timeout.
- Sits between the instruction register's opcode field and the datapath enables.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for MemReady in FETCH or MEM before fault (1..255)
OPW, 4, opcode width

Ports:
Clk  input  1  system clock; all state updates on rising edge
Rst  input  1  synchronous, active-high reset
Run  input  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
Opcode  input  OPW  opcode field from instruction register output
Zero  input  1  ALU zero flag, used by JZ
MemReady  input  1  memory completes current read/write this cycle
MemRd  output  1  memory read request
MemWr  output  1  memory write request
IrLoad  output  1  load instruction register
PcInc  output  1  increment PC
PcLoad  output  1  load PC from branch target
RegWe  output  1  register file write enable
AluOp  output  3  ALU function: 0 pass, 1 add, 2 sub, 3 and, 4 or
State  output  3  current state encoding
Halted  output  1  1 in HALT
Fault  output  1  sticky memory-timeout flag
InstrCount  output  16  retired instruction count (see Optional Feature)

Behaviour:
- Reset (Rst=1 at edge, any state, mid-transaction included): State=IDLE, timeout counter=0, Fault=0, InstrCount=0, latched opcode=0. All strobes are 0 in IDLE.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=7.
- Outputs are decoded from State and the latched opcode. The one exception is the MemReady-qualified strobes below.
- IDLE: all strobes 0. Run=1 -> FETCH.
- FETCH: MemRd=1.
  - MemReady=1: IrLoad=1 and PcInc=1 in the same cycle -> DECODE.
  - Otherwise the timeout counter increments.
- DECODE: latch Opcode into an internal register; no strobes.
  - 0xF -> HALT; all other opcodes -> EXEC.
- EXEC, by latched opcode:
  - 0 NOP: no strobes.
  - 1 ADD / 2 SUB / 3 AND / 4 OR: AluOp = 1/2/3/4, RegWe=1.
  - 5 LD / 6 ST: -> MEM.
  - 7 JMP: PcLoad=1.
  - 8 JZ: PcLoad=Zero.
  - 9..0xE (illegal): treated as NOP.
  - Every EXEC exit other than to MEM counts as an instruction retire.
- MEM: LD holds MemRd=1; ST holds MemWr=1.
  - On MemReady=1: LD asserts RegWe=1 that cycle with AluOp=0; the instruction retires.
  - Without MemReady the timeout counter increments.
- Retire transition: Run=1 -> FETCH; Run=0 -> IDLE. Run is sampled only at the retire point; deassertion mid-instruction does not abort.
- Timeout counter:
  - Cleared on every entry to FETCH or MEM.
  - When the counter = MEM_TIMEOUT and MemReady=0: -> HALT, Fault<=1, all strobes dropped next cycle.
  - MemReady=1 in the same cycle as the timeout wins; no fault.
  - Counter width is 8 bits; it never wraps because the timeout triggers first.
- HALT: Halted=1, no strobes, exited only by Rst. Run is ignored.
- Each strobe is high for exactly the cycles stated; the datapath samples it at the following rising edge.
- Throughput with zero-wait memory: ALU/branch/NOP instructions take 3 cycles; LD/ST take 4.

Optional Feature:
- Macro: CPU_SEQ_INSTR_COUNT_EN.
- Defined: 16-bit InstrCount increments by 1 on each retire, wraps 0xFFFF->0x0000, and is cleared by Rst. HLT and faulted instructions do not count.
- Undefined: InstrCount is tied to 16'h0000 and no counter flops are built.

Test Plan:
- Rst, then Run=1, MemReady=1, Opcode=1 (ADD) -> State sequence 0,1,2,3,1. IrLoad/PcInc pulse in cycle 1; RegWe=1 with AluOp=1 in cycle 3. InstrCount=1 after retire.
- LD with MemReady delayed 3 cycles in MEM -> MemRd held 4 cycles; RegWe=1 only in the MemReady cycle; then FETCH.
- JZ with Zero=0, then JZ with Zero=1 -> PcLoad 0, then PcLoad 1 in the respective EXEC cycle.
- FETCH with MemReady held 0 and MEM_TIMEOUT=15 -> HALT after the counter reaches 15. Fault=1, Halted=1, MemRd=0 in HALT; Run toggling has no effect until Rst.
- Run dropped during EXEC of an OR -> the OR completes (RegWe=1, AluOp=4), State goes to IDLE, and no further MemRd appears.
- Opcode=0xF -> DECODE then HALT, InstrCount unchanged. Rst asserted during MEM of a ST -> next cycle State=0, MemWr=0, Fault=0.
